// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine change path.
//   CHG_W        : width of a change request, in nickels
//   NICKEL_CENTS : face value of one dispensed coin
//   disp_state_e : change dispenser FSM states
package vend_pkg;

    localparam int unsigned CHG_W        = 3;
    localparam int unsigned NICKEL_CENTS = 5;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT,
        GAP,
        STARVE,
        JAM
    } disp_state_e;

endpackage

// File: rtl/chg_req_fifo.sv
// Synchronous FIFO holding pending change requests.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/data_i : write request and data
//   pop_i         : read request; data_o shows the head entry
//   full_o/empty_o: occupancy flags
module chg_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB distinguishes full from empty when the indices match.
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues change requests from the vend controller and
// ejects nickels one at a time, confirming each with the hopper sensor.
// Missed coins are re-pulsed up to MAX_RETRY times before a jam is latched.
// Ports:
//   soda_i/change_i : vend strobe and nickels owed (pushed when change_i != 0)
//   coin_seen_i     : hopper exit sensor pulse
//   clr_jam_i       : service clear of a latched jam
//   inv_load_i/inv_val_i : load the hopper inventory count
//   eject_o         : solenoid drive
//   busy_o          : request in progress or queued
//   jam_o, empty_o  : jam latched, inventory exhausted
//   drop_o          : request lost because the queue was full
//   inv_cnt_o       : current inventory
// Optional: define CHANGE_DISPENSER_STATS_EN to add disp_total_o and
// retry_total_o saturating event counters.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned INV_W          = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             soda_i,
    input  logic [CHG_W-1:0] change_i,
    input  logic             coin_seen_i,
    input  logic             clr_jam_i,
    input  logic             inv_load_i,
    input  logic [INV_W-1:0] inv_val_i,
    output logic             eject_o,
    output logic             busy_o,
    output logic             jam_o,
    output logic             empty_o,
    output logic             drop_o,
`ifdef CHANGE_DISPENSER_STATS_EN
    output logic [15:0]      disp_total_o,
    output logic [15:0]      retry_total_o,
`endif
    output logic [INV_W-1:0] inv_cnt_o
);

    localparam int unsigned MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (TIMEOUT_CYCLES > MAX_PG) ? TIMEOUT_CYCLES : MAX_PG;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    disp_state_e        state_q;
    logic [CHG_W-1:0]   remain_q;
    logic [RETRY_W-1:0] retry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               eject_q;
    logic               jam_q;
    logic               drop_q;
    logic [INV_W-1:0]   inv_q;
    logic [INV_W-1:0]   inv_d;

    logic               push_req;
    logic               pop;
    logic               coin_ok;
    logic               timeout;
    logic [CHG_W-1:0]   fifo_data;
    logic               fifo_full;
    logic               fifo_empty;

    assign push_req = soda_i && (change_i != '0);
    // Never pop with an empty hopper: the request stays queued until refill.
    assign pop      = (state_q == IDLE) && !fifo_empty && (inv_q != '0);
    assign coin_ok  = (state_q == WAIT) && coin_seen_i;
    assign timeout  = (state_q == WAIT) && !coin_seen_i && (cnt_q == TIMEOUT_LAST);

    chg_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHG_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_req),
        .data_i  (change_i),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A load wins over a same-cycle coin decrement.
    always_comb begin
        inv_d = inv_q;
        if (inv_load_i) begin
            inv_d = inv_val_i;
        end else if (coin_ok && (inv_q != '0)) begin
            inv_d = inv_q - INV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            remain_q <= '0;
            retry_q  <= '0;
            cnt_q    <= '0;
            eject_q  <= 1'b0;
            jam_q    <= 1'b0;
            drop_q   <= 1'b0;
            inv_q    <= '0;
        end else begin
            drop_q <= push_req && fifo_full && !pop;
            inv_q  <= inv_d;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (inv_q != '0) begin
                            remain_q <= fifo_data;
                            retry_q  <= '0;
                            cnt_q    <= '0;
                            eject_q  <= 1'b1;
                            state_q  <= PULSE;
                        end else begin
                            state_q <= STARVE;
                        end
                    end
                end
                PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_q   <= '0;
                        eject_q <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (coin_seen_i) begin
                        remain_q <= remain_q - CHG_W'(1);
                        retry_q  <= '0;
                        cnt_q    <= '0;
                        if (remain_q == CHG_W'(1)) begin
                            state_q <= IDLE;
                        end else if (inv_d == '0) begin
                            state_q <= STARVE;
                        end else begin
                            state_q <= GAP;
                        end
                    end else if (timeout) begin
                        cnt_q <= '0;
                        if (retry_q < RETRY_LIMIT) begin
                            retry_q <= retry_q + RETRY_W'(1);
                            eject_q <= 1'b1;
                            state_q <= PULSE;
                        end else begin
                            jam_q   <= 1'b1;
                            state_q <= JAM;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        eject_q <= 1'b1;
                        state_q <= PULSE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STARVE: begin
                    if (inv_load_i && (inv_val_i != '0)) begin
                        cnt_q   <= '0;
                        state_q <= (remain_q != '0) ? GAP : IDLE;
                    end
                end
                JAM: begin
                    // remain_q is kept so the interrupted request resumes.
                    if (clr_jam_i) begin
                        jam_q   <= 1'b0;
                        retry_q <= '0;
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eject_o   = eject_q;
    assign jam_o     = jam_q;
    assign drop_o    = drop_q;
    assign inv_cnt_o = inv_q;
    assign empty_o   = (inv_q == '0);
    assign busy_o    = (state_q != IDLE) || !fifo_empty;

`ifdef CHANGE_DISPENSER_STATS_EN
    logic [15:0] disp_total_q;
    logic [15:0] retry_total_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            disp_total_q  <= '0;
            retry_total_q <= '0;
        end else begin
            if (coin_ok && (disp_total_q != 16'hFFFF)) begin
                disp_total_q <= disp_total_q + 16'd1;
            end
            if (timeout && (retry_total_q != 16'hFFFF)) begin
                retry_total_q <= retry_total_q + 16'd1;
            end
        end
    end

    assign disp_total_o  = disp_total_q;
    assign retry_total_o = retry_total_q;
`endif

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending machine controller.
- Consumes the vend event (soda) and the change amount, in nickels, that the controller produces.
- Drives a physical nickel-ejector solenoid one coin at a time and confirms each coin with a sensor. Retries on a missed coin, flags a jam, and tracks the nickel inventory in the hopper.
- Requests are buffered so the controller never stalls.

Parameters:
- DEPTH, 4: entries in the change-request FIFO (power of 2, ≥2).
- PULSE_CYCLES, 4: cycles eject_o is held high per attempt.
- GAP_CYCLES, 2: idle cycles between consecutive coins.
- TIMEOUT_CYCLES, 16: cycles to wait for coin_seen_i after the pulse ends.
- MAX_RETRY, 2: re-pulses allowed per coin before declaring a jam.
- INV_W, 8: inventory counter width.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset
- soda_i  in  1  one-cycle vend strobe from the controller
- change_i  in  3  nickels owed, sampled with soda_i
- coin_seen_i  in  1  hopper exit sensor, one-cycle pulse per coin
- clr_jam_i  in  1  service clear of the jam condition
- inv_load_i  in  1  load the inventory count
- inv_val_i  in  INV_W  inventory load value
- eject_o  out  1  solenoid drive
- busy_o  out  1  request in progress or FIFO non-empty
- jam_o  out  1  jam latched
- empty_o  out  1  inventory is zero
- drop_o  out  1  one-cycle pulse: request lost, FIFO full
- inv_cnt_o  out  INV_W  current inventory

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_ni is synchronous, active-low. Reset values:
  - eject_o=0, busy_o=0, jam_o=0, drop_o=0, inv_cnt_o=0.
  - empty_o=1.
  - FIFO empty, state IDLE, all counters 0.
  - Reset mid-dispense aborts immediately; eject_o is low on the next edge.
- Push:
  - soda_i=1 and change_i!=0 pushes change_i.
  - soda_i=1 with change_i=0, or change_i without soda_i, is ignored.
  - Push while full and no pop that cycle: entry discarded, drop_o=1 for one cycle.
  - Push while full with a same-cycle pop is accepted.
- FSM states: IDLE, PULSE, WAIT, GAP, STARVE, JAM.
- IDLE:
  - If the FIFO is non-empty and inv_cnt>0: pop into remain, retry=0, go to PULSE.
  - Pop-to-eject latency is 1 cycle (eject_o high the cycle after the pop edge).
  - If the FIFO is non-empty and inv_cnt=0: go to STARVE without popping.
- PULSE: eject_o=1 for exactly PULSE_CYCLES cycles, then go to WAIT.
- WAIT (eject_o=0):
  - coin_seen_i within TIMEOUT_CYCLES cycles: remain-1, inv_cnt-1, retry=0.
  - Then: if remain=0, go to IDLE; else if inv_cnt(new)=0, go to STARVE; else go to GAP.
  - On timeout: retry+1. If retry<MAX_RETRY, go to PULSE; else go to JAM.
- GAP: GAP_CYCLES idle cycles, then go to PULSE.
- STARVE:
  - empty_o=1, eject_o=0.
  - On inv_load_i with inv_val_i!=0: go to GAP if remain>0, else go to IDLE.
- JAM:
  - jam_o=1, eject_o=0; FIFO still accepts pushes.
  - clr_jam_i: jam_o=0, retry=0, go to GAP.
  - The remaining nickels of the current request are preserved.
- Spurious sensor: coin_seen_i outside WAIT is ignored; inventory is unchanged.
- Inventory:
  - inv_load_i overrides a same-cycle decrement.
  - The decrement saturates at 0.
  - empty_o = (inv_cnt==0).
- busy_o = (state!=IDLE) | FIFO non-empty.

Optional Feature:
- Macro: CHANGE_DISPENSER_STATS_EN.
- Defined: adds two outputs, both cleared by reset and saturating at 2^16-1:
  - disp_total_o[15:0]: increments on each confirmed coin.
  - retry_total_o[15:0]: increments on each timeout.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package vend_pkg:
  - CHG_W=3.
  - disp_state_e enum (IDLE, PULSE, WAIT, GAP, STARVE, JAM).
  - Nickel value constant NICKEL_CENTS=5.
- Sub-module chg_req_fifo: synchronous FIFO, width CHG_W, depth DEPTH, with full/empty flags and same-cycle push/pop when full.

Test Plan:
- Nominal dispense: inv load 10; soda_i with change_i=3; sensor answers 2 cycles after each pulse → 3 pulses of 4 cycles separated by the GAP period; inv_cnt_o=7; busy_o falls after the third coin.
- Retry and jam: inv=5, change=1, no sensor → 3 pulses total (1 + MAX_RETRY), then jam_o=1. clr_jam_i, then sensor answers → coin dispensed, inv=4, jam_o=0.
- Starve: inv=1, change=2 → after 1 coin empty_o=1, state STARVE, eject_o stays 0. Load 5 → second coin dispensed, final inv=4.
- Overflow: with the dispenser stalled (inv=0), issue 5 soda_i strobes with change=1 → 4 entries queued; drop_o pulses once on the 5th.
- Ignore rules: soda_i with change=0, change_i without soda_i, and coin_seen_i in IDLE → no push, no inventory change.
- Reset mid-pulse: assert rst_ni=0 during PULSE → next edge eject_o=0, FIFO empty, inv_cnt_o=0, empty_o=1.
